fetch_ctrl: RTL and testbench

Instruction-fetch controller sitting between the 64-word instruction memory and the IF/ID pipeline register. It sequences the fetch PC, drives the memory word address, and buffers fetched instructions in a small prefetch queue so decode back-pressure never loses a fetch. It also applies branch/jump redirects with queue flush, and flags out-of-range or misaligned fetches.

---
 rtl/fetch_ctrl.sv | 85 ++++++++
 tb/tb_fetch_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, prefetch queue,
// redirect flush and sticky out-of-range / misaligned fetch fault.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64,
  parameter int          QDEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);

  logic [31:0]   fpc;
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  logic legal;
  logic pop;
  logic attempt;
  logic push;

  assign imem_addr = {2'b00, fpc[31:2]};
  assign legal     = (fpc[1:0] == 2'b00) &&
                     (imem_addr < 32'(MEM_WORDS));
  assign if_valid  = (count != '0);
  assign if_pc     = q_pc[rd_ptr];
  assign if_inst   = q_inst[rd_ptr];
  assign pop       = if_valid & if_ready;
  assign attempt   = fetch_en & ~redirect & ~fault;
  assign push      = attempt & legal &
                     ((count != QFULL) | pop);

  // PC, queue and fault state; redirect flushes and wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fault  <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (redirect) begin
      fpc    <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fault  <= 1'b0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]   <= fpc;
        q_inst[wr_ptr] <= imem_data;
        wr_ptr         <= wr_ptr + 1'b1;
        fpc            <= fpc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (attempt && !legal)
        fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural
// combinational instruction memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fault;

  int vectors = 0;
  int miscompares = 0;

  fetch_ctrl dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .if_valid(if_valid),
    .if_inst(if_inst),
    .if_pc(if_pc),
    .if_ready(if_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'd0)      return 32'h0000_0083;
    else if (a == 32'd1) return 32'h0020_1103;
    else                 return 32'hA500_0000 | a;
  endfunction

  assign imem_data = (imem_addr < 32'd64) ? memw(imem_addr)
                                          : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    @(negedge clk);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    step();
    chk("rst_hold_valid", 32'(if_valid), 32'd0);
    rst = 1'b1;

    // streaming from reset
    step();
    chk("s0_valid", 32'(if_valid), 32'd1);
    chk("s0_pc", if_pc, 32'h0);
    chk("s0_inst", if_inst, 32'h0000_0083);
    step();
    chk("s1_pc", if_pc, 32'h4);
    chk("s1_inst", if_inst, 32'h0020_1103);
    step();
    chk("s2_pc", if_pc, 32'h8);
    chk("s2_inst", if_inst, 32'hA500_0002);

    // build count=3, then async reset mid-cycle
    if_ready = 1'b0;
    step();
    step();
    chk("pre_rst_valid", 32'(if_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 32'(if_valid), 32'd0);
    chk("async_fault", 32'(fault), 32'd0);
    chk("async_addr", imem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // stall: exactly four pushes, fpc stops at 0x10
    for (int i = 0; i < 10; i++) step();
    chk("stall_addr", imem_addr, 32'd4);
    chk("stall_valid", 32'(if_valid), 32'd1);
    chk("stall_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("drain_pc%0d", i), if_pc, 32'(4 * i));
      chk($sformatf("drain_inst%0d", i), if_inst, memw(32'(i)));
      step();
    end
    // head 0x1C, queue still full (fpc = 0x2C)
    chk("full_addr", imem_addr, 32'd11);

    // redirect with pop while full
    redirect = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    chk("rd_valid", 32'(if_valid), 32'd0);
    chk("rd_addr", imem_addr, 32'd8);
    step();
    chk("rd_valid2", 32'(if_valid), 32'd1);
    chk("rd_pc", if_pc, 32'h20);
    chk("rd_inst", if_inst, 32'hA500_0008);

    // run off the end of memory
    n = 0;
    while (imem_addr != 32'd64 && n < 100) begin
      step();
      n++;
    end
    chk("end_addr", imem_addr, 32'd64);
    chk("end_pc", if_pc, 32'hFC);
    chk("end_fault0", 32'(fault), 32'd0);
    step();
    chk("oob_fault", 32'(fault), 32'd1);
    chk("oob_valid", 32'(if_valid), 32'd0);
    chk("oob_addr", imem_addr, 32'd64);
    step();
    chk("oob_fault2", 32'(fault), 32'd1);
    chk("oob_valid2", 32'(if_valid), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    chk("rec_fault", 32'(fault), 32'd0);
    chk("rec_addr", imem_addr, 32'd0);
    step();
    chk("rec_valid", 32'(if_valid), 32'd1);
    chk("rec_pc", if_pc, 32'h0);

    // misaligned redirect target
    redirect = 1'b1;
    redirect_pc = 32'h6;
    step();
    redirect = 1'b0;
    chk("mis_fault0", 32'(fault), 32'd0);
    chk("mis_addr", imem_addr, 32'd1);
    step();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_valid", 32'(if_valid), 32'd0);
    step();
    chk("mis_valid2", 32'(if_valid), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h8;
    step();
    redirect = 1'b0;
    chk("mis_rec_fault", 32'(fault), 32'd0);
    step();
    chk("mis_rec_valid", 32'(if_valid), 32'd1);
    chk("mis_rec_pc", if_pc, 32'h8);
    chk("mis_rec_inst", if_inst, 32'hA500_0002);

    // fetch_en low: PC holds, queue drains
    fetch_en = 1'b0;
    step();
    chk("fe_valid", 32'(if_valid), 32'd0);
    chk("fe_addr", imem_addr, 32'd3);
    step();
    chk("fe_addr2", imem_addr, 32'd3);
    fetch_en = 1'b1;
    step();
    chk("fe_pc", if_pc, 32'hC);
    chk("fe_valid2", 32'(if_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
